// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, FSM states,
// and the opcode to one-hot strobe mapping used in the ISSUE cycle.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_INC = 4'd2;
    localparam logic [3:0] OP_DEC = 4'd3;
    localparam logic [3:0] OP_MUL = 4'd4;
    localparam logic [3:0] OP_SHR = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_AND = 4'd7;
    localparam logic [3:0] OP_OR  = 4'd8;
    localparam logic [3:0] OP_XOR = 4'd9;
    localparam logic [3:0] OP_NOT = 4'd10;
    localparam logic [3:0] OP_MOV = 4'd11;

    localparam int NSTRB = 11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_COLLECT
    } state_t;

    function automatic logic op_legal(input logic [3:0] op);
        return op <= OP_MOV;
    endfunction

    // Bit i of the result is the strobe for opcode i; MOV and
    // illegal opcodes map to no strobe at all.
    function automatic logic [NSTRB-1:0] op_strobe(input logic [3:0] op);
        logic [NSTRB-1:0] s;
        s = '0;
        if (op <= OP_NOT) s[op] = 1'b1;
        return s;
    endfunction

endpackage

// File: rtl/regfile8x16.sv
// Register file: two operand read ports, one debug read port, write-back
// lo/hi ports and a preload port. Priority: wb hi > wb lo > preload.
module regfile8x16 #(
    parameter int NREGS = 8,
    parameter int W     = 16,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] ra_addr,
    output logic [W-1:0]  ra_data,
    input  logic [AW-1:0] rb_addr,
    output logic [W-1:0]  rb_data,
    input  logic [AW-1:0] dbg_addr,
    output logic [W-1:0]  dbg_data,
    input  logic          lo_en,
    input  logic [AW-1:0] lo_addr,
    input  logic [W-1:0]  lo_data,
    input  logic          hi_en,
    input  logic [AW-1:0] hi_addr,
    input  logic [W-1:0]  hi_data,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [W-1:0]  ld_data
);

    logic [W-1:0] mem [NREGS];

    assign ra_data  = mem[ra_addr];
    assign rb_data  = mem[rb_addr];
    assign dbg_data = mem[dbg_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (hi_en && hi_addr == AW'(i))
                    mem[i] <= hi_data;
                else if (lo_en && lo_addr == AW'(i))
                    mem[i] <= lo_data;
                else if (ld_en && ld_addr == AW'(i))
                    mem[i] <= ld_data;
            end
        end
    end

endmodule

// File: rtl/alu_issue.sv
// Command sequencer for the two-operand logic unit: IDLE -> ISSUE -> COLLECT.
// Ports: cmd handshake/fields, preload, debug read, operand buses, op
// strobes, output enables, result buses, done/err completion pulse.
module alu_issue
    import alu_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int W     = 16,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [3:0]    cmd_op,
    input  logic [AW-1:0] cmd_ra,
    input  logic [AW-1:0] cmd_rb,
    input  logic [AW-1:0] cmd_rd,
    input  logic          cmd_wide,
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_addr,
    input  logic [W-1:0]  ld_data,
    input  logic [AW-1:0] dbg_addr,
    output logic [W-1:0]  dbg_data,
    output logic [W-1:0]  bus1,
    output logic [W-1:0]  bus2,
    output logic          add,
    output logic          sub,
    output logic          inc,
    output logic          dec,
    output logic          mul,
    output logic          shr,
    output logic          shl,
    output logic          band,
    output logic          bor,
    output logic          bxor,
    output logic          bnegate,
    output logic          pass,
    output logic          pass_high,
    output logic          push,
    output logic          push_high,
    input  logic [W-1:0]  bus3,
    input  logic [W-1:0]  bus4,
    output logic          done,
    output logic          err
);

    state_t state, state_nx;

    logic [3:0]       op_q;
    logic [AW-1:0]    rd_q;
    logic             wide_q;
    logic [W-1:0]     a_q, b_q;
    logic [W-1:0]     ra_data, rb_data;
    logic             accept;
    logic             legal, is_mov;
    logic             we_lo, we_hi;
    logic [NSTRB-1:0] strb;

    assign accept = cmd_valid && cmd_ready;
    assign legal  = op_legal(op_q);
    assign is_mov = (op_q == OP_MOV);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        strb      = '0;
        push      = 1'b0;
        push_high = 1'b0;
        pass      = 1'b0;
        pass_high = 1'b0;
        bus1      = '0;
        bus2      = '0;
        we_lo     = 1'b0;
        unique case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nx = S_ISSUE;
            end
            S_ISSUE: begin
                bus1     = a_q;
                bus2     = b_q;
                strb     = op_strobe(op_q);
                state_nx = S_COLLECT;
            end
            S_COLLECT: begin
                bus1      = a_q;
                bus2      = b_q;
                push      = legal && !is_mov;
                push_high = legal && !is_mov;
                pass      = is_mov;
                pass_high = is_mov;
                we_lo     = legal;
                state_nx  = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign we_hi = we_lo && wide_q;

    assign {bnegate, bxor, bor, band, shl, shr,
            mul, dec, inc, sub, add} = strb;

    // Operands are snapshotted at accept so later preloads or write-backs
    // to the source registers cannot disturb an in-flight command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= '0;
            rd_q   <= '0;
            wide_q <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
        end else if (accept) begin
            op_q   <= cmd_op;
            rd_q   <= cmd_rd;
            wide_q <= cmd_wide;
            a_q    <= ra_data;
            b_q    <= rb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
            err  <= 1'b0;
        end else begin
            done <= (state == S_COLLECT);
            err  <= (state == S_COLLECT) && !legal;
        end
    end

    regfile8x16 #(
        .NREGS(NREGS),
        .W    (W)
    ) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .ra_addr (cmd_ra),
        .ra_data (ra_data),
        .rb_addr (cmd_rb),
        .rb_data (rb_data),
        .dbg_addr(dbg_addr),
        .dbg_data(dbg_data),
        .lo_en   (we_lo),
        .lo_addr (rd_q),
        .lo_data (bus3),
        .hi_en   (we_hi),
        .hi_addr (rd_q + AW'(1)),
        .hi_data (bus4),
        .ld_en   (ld_valid),
        .ld_addr (ld_addr),
        .ld_data (ld_data)
    );

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural logic-unit model that
// latches its result on a strobe and drives bus3/bus4 when enabled.
module tb_alu_issue;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [2:0]  cmd_ra, cmd_rb, cmd_rd;
    logic        cmd_wide;
    logic        ld_valid;
    logic [2:0]  ld_addr;
    logic [15:0] ld_data;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;
    logic [15:0] bus1, bus2;
    wire  [15:0] bus3, bus4;
    logic add, sub, inc, dec, mul, shr, shl, band, bor, bxor, bnegate;
    logic pass, pass_high, push, push_high;
    logic done, err;

    int checks = 0;
    int errors = 0;

    logic [10:0] strobes;
    logic [3:0]  enables;
    assign strobes = {bnegate, bxor, bor, band, shl, shr,
                      mul, dec, inc, sub, add};
    assign enables = {push, push_high, pass, pass_high};

    alu_issue dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_ra   (cmd_ra),
        .cmd_rb   (cmd_rb),
        .cmd_rd   (cmd_rd),
        .cmd_wide (cmd_wide),
        .ld_valid (ld_valid),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .bus1     (bus1),
        .bus2     (bus2),
        .add      (add),
        .sub      (sub),
        .inc      (inc),
        .dec      (dec),
        .mul      (mul),
        .shr      (shr),
        .shl      (shl),
        .band     (band),
        .bor      (bor),
        .bxor     (bxor),
        .bnegate  (bnegate),
        .pass     (pass),
        .pass_high(pass_high),
        .push     (push),
        .push_high(push_high),
        .bus3     (bus3),
        .bus4     (bus4),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Logic unit model
    logic [15:0] lu_lo, lu_hi;

    function automatic logic [31:0] lu_calc(input logic [10:0] s,
                                            input logic [15:0] a,
                                            input logic [15:0] b);
        logic [31:0] r;
        r = '0;
        if (s[0])       r[15:0] = a + b;
        else if (s[1])  r[15:0] = a - b;
        else if (s[2])  r[15:0] = a + 16'd1;
        else if (s[3])  r[15:0] = a - 16'd1;
        else if (s[4])  r = {16'h0, a} * {16'h0, b};
        else if (s[5])  r[15:0] = a >> b;
        else if (s[6])  r[15:0] = a << b;
        else if (s[7])  r[15:0] = a & b;
        else if (s[8])  r[15:0] = a | b;
        else if (s[9])  r[15:0] = a ^ b;
        else if (s[10]) r[15:0] = ~b;
        return r;
    endfunction

    always @(posedge clk) begin
        if (|strobes) {lu_hi, lu_lo} <= lu_calc(strobes, bus1, bus2);
    end

    assign bus3 = push ? lu_lo : pass ? bus1 : 16'hzzzz;
    assign bus4 = push_high ? lu_hi : pass_high ? bus2 : 16'hzzzz;

    // Observations captured by run_cmd
    logic [10:0] iss_strb, col_strb;
    logic [3:0]  iss_en, col_en;
    logic        rdy_acc, done_seen, err_seen, done_after;
    logic [15:0] rv;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input logic [2:0] a, output logic [15:0] d);
        dbg_addr = a;
        #1;
        d = dbg_data;
    endtask

    task automatic preload(input logic [2:0] a, input logic [15:0] d);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic [3:0] op, input logic [2:0] ra,
                           input logic [2:0] rb, input logic [2:0] rd,
                           input logic wide);
        cmd_op    = op;
        cmd_ra    = ra;
        cmd_rb    = rb;
        cmd_rd    = rd;
        cmd_wide  = wide;
        cmd_valid = 1'b1;
        rdy_acc   = cmd_ready;
        tick();
        cmd_valid = 1'b0;
        iss_strb  = strobes;
        iss_en    = enables;
        tick();
        col_strb  = strobes;
        col_en    = enables;
        tick();
        done_seen = done;
        err_seen  = err;
        tick();
        done_after = done;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_ra    = '0;
        cmd_rb    = '0;
        cmd_rd    = '0;
        cmd_wide  = 1'b0;
        ld_valid  = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;
        dbg_addr  = '0;
        #12;
        checks++;
        if ({strobes, enables, done, err} !== 17'h0) begin
            errors++;
            $display("FAIL reset_outs got %h want 0",
                     {strobes, enables, done, err});
        end
        checks++;
        if ({bus1, bus2} !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus got %h want 0", {bus1, bus2});
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", cmd_ready);
        end
        peek(3'd5, rv);
        checks++;
        if (rv !== 16'h0) begin
            errors++;
            $display("FAIL reset_r5 got %h want 0000", rv);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_add;
        preload(3'd1, 16'h0003);
        preload(3'd2, 16'h0005);
        run_cmd(4'd0, 3'd1, 3'd2, 3'd3, 1'b0);
        checks++;
        if (rdy_acc !== 1'b1) begin
            errors++;
            $display("FAIL add_ready got %b want 1", rdy_acc);
        end
        checks++;
        if (iss_strb !== 11'h001 || iss_en !== 4'h0) begin
            errors++;
            $display("FAIL add_issue got %h/%h want 001/0",
                     iss_strb, iss_en);
        end
        checks++;
        if (col_strb !== 11'h000 || col_en !== 4'b1100) begin
            errors++;
            $display("FAIL add_collect got %h/%b want 000/1100",
                     col_strb, col_en);
        end
        checks++;
        if (done_seen !== 1'b1 || err_seen !== 1'b0 || done_after !== 1'b0) begin
            errors++;
            $display("FAIL add_done got %b%b%b want 100",
                     done_seen, err_seen, done_after);
        end
        peek(3'd3, rv);
        checks++;
        if (rv !== 16'h0008) begin
            errors++;
            $display("FAIL add_r3 got %h want 0008", rv);
        end
    endtask

    task automatic test_mul_wide;
        preload(3'd1, 16'hFFFF);
        preload(3'd2, 16'h0002);
        run_cmd(4'd4, 3'd1, 3'd2, 3'd7, 1'b1);
        checks++;
        if (iss_strb !== 11'h010) begin
            errors++;
            $display("FAIL mul_strobe got %h want 010", iss_strb);
        end
        checks++;
        if (col_en !== 4'b1100) begin
            errors++;
            $display("FAIL mul_enables got %b want 1100", col_en);
        end
        peek(3'd7, rv);
        checks++;
        if (rv !== 16'hFFFE) begin
            errors++;
            $display("FAIL mul_r7 got %h want fffe", rv);
        end
        peek(3'd0, rv);
        checks++;
        if (rv !== 16'h0001) begin
            errors++;
            $display("FAIL mul_r0_wrap got %h want 0001", rv);
        end
    endtask

    task automatic test_mov;
        run_cmd(4'd11, 3'd1, 3'd2, 3'd4, 1'b1);
        checks++;
        if (iss_strb !== 11'h000 || col_strb !== 11'h000) begin
            errors++;
            $display("FAIL mov_strobe got %h/%h want 000/000",
                     iss_strb, col_strb);
        end
        checks++;
        if (col_en !== 4'b0011) begin
            errors++;
            $display("FAIL mov_enables got %b want 0011", col_en);
        end
        peek(3'd4, rv);
        checks++;
        if (rv !== 16'hFFFF) begin
            errors++;
            $display("FAIL mov_r4 got %h want ffff", rv);
        end
        peek(3'd5, rv);
        checks++;
        if (rv !== 16'h0002) begin
            errors++;
            $display("FAIL mov_r5 got %h want 0002", rv);
        end
    endtask

    task automatic test_illegal;
        preload(3'd6, 16'h1234);
        run_cmd(4'd13, 3'd1, 3'd2, 3'd6, 1'b1);
        checks++;
        if ({iss_strb, col_strb} !== 22'h0 || {iss_en, col_en} !== 8'h0) begin
            errors++;
            $display("FAIL ill_quiet got %h/%h want 0/0",
                     {iss_strb, col_strb}, {iss_en, col_en});
        end
        checks++;
        if (done_seen !== 1'b1 || err_seen !== 1'b1) begin
            errors++;
            $display("FAIL ill_done_err got %b%b want 11",
                     done_seen, err_seen);
        end
        peek(3'd6, rv);
        checks++;
        if (rv !== 16'h1234) begin
            errors++;
            $display("FAIL ill_r6 got %h want 1234", rv);
        end
        peek(3'd7, rv);
        checks++;
        if (rv !== 16'hFFFE) begin
            errors++;
            $display("FAIL ill_r7 got %h want fffe", rv);
        end
    endtask

    task automatic test_back_to_back;
        // first: R3 = FFFF + 0002 = 0001
        cmd_op    = 4'd0;
        cmd_ra    = 3'd1;
        cmd_rb    = 3'd2;
        cmd_rd    = 3'd3;
        cmd_wide  = 1'b0;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        // done cycle of the first: offer the second immediately
        checks++;
        if (done !== 1'b1 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done_ready got %b%b want 11",
                     done, cmd_ready);
        end
        cmd_op    = 4'd0;
        cmd_ra    = 3'd3;
        cmd_rb    = 3'd3;
        cmd_rd    = 3'd6;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (add !== 1'b1 || bus1 !== 16'h0001 || bus2 !== 16'h0001) begin
            errors++;
            $display("FAIL b2b_issue got add=%b %h %h want 1 0001 0001",
                     add, bus1, bus2);
        end
        // preload a source during ISSUE; in-flight operands must hold
        ld_valid = 1'b1;
        ld_addr  = 3'd3;
        ld_data  = 16'h7777;
        tick();
        ld_valid = 1'b0;
        checks++;
        if (bus1 !== 16'h0001 || push !== 1'b1) begin
            errors++;
            $display("FAIL b2b_snapshot got %h push=%b want 0001 1",
                     bus1, push);
        end
        tick();
        peek(3'd6, rv);
        checks++;
        if (rv !== 16'h0002) begin
            errors++;
            $display("FAIL b2b_r6 got %h want 0002", rv);
        end
        peek(3'd3, rv);
        checks++;
        if (rv !== 16'h7777) begin
            errors++;
            $display("FAIL b2b_r3 got %h want 7777", rv);
        end
        tick();
    endtask

    task automatic test_wb_priority;
        // XOR FFFF ^ 0002 = FFFD, preload to R3 in the COLLECT cycle
        cmd_op    = 4'd9;
        cmd_ra    = 3'd1;
        cmd_rb    = 3'd2;
        cmd_rd    = 3'd3;
        cmd_wide  = 1'b0;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        ld_valid = 1'b1;
        ld_addr  = 3'd3;
        ld_data  = 16'hAAAA;
        tick();
        ld_valid = 1'b0;
        peek(3'd3, rv);
        checks++;
        if (rv !== 16'hFFFD) begin
            errors++;
            $display("FAIL wb_priority_r3 got %h want fffd", rv);
        end
        tick();
    endtask

    task automatic test_reset_mid;
        cmd_op    = 4'd0;
        cmd_ra    = 3'd1;
        cmd_rb    = 3'd2;
        cmd_rd    = 3'd5;
        cmd_wide  = 1'b1;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        checks++;
        if (push !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_collect got push=%b want 1", push);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({strobes, enables, done, err} !== 17'h0 ||
            {bus1, bus2} !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_outs got %h %h want 0 0",
                     {strobes, enables, done, err}, {bus1, bus2});
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_done got %b want 0", done);
        end
        peek(3'd5, rv);
        checks++;
        if (rv !== 16'h0000) begin
            errors++;
            $display("FAIL rstmid_r5 got %h want 0000", rv);
        end
        tick();
        checks++;
        if (done !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_idle got %b%b want 01", done, cmd_ready);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul_wide();
        test_mov();
        test_illegal();
        test_back_to_back();
        test_wb_priority();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
